// File: rtl/adc_pd_if.sv
// ADC power-control bundle: power-down pin and ready flag.
// master drives the pins (sequencer), slave observes them (capture logic).
interface adc_pd_if;
    logic PD;
    logic ADC_ready;

    modport master (output PD, output ADC_ready);
    modport slave  (input  PD, input  ADC_ready);
endinterface

// File: rtl/adc_pd.sv
// ADC power-up sequencer: hold PD high, release it, wait for converter wake-up,
// then raise a sticky ready flag that only reset clears.
module adc_pd #(
    parameter int PD_HOLD_CYCLES = 20,
    parameter int WAKE_CYCLES    = 40
) (
    input  logic      clk_200kHz,
    input  logic      reset,
    adc_pd_if.master  o_adc
);
    localparam int MAX_CYCLES = (PD_HOLD_CYCLES > WAKE_CYCLES) ? PD_HOLD_CYCLES : WAKE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(PD_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_WAKE  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_pd;
    logic            r_ready;

    // Outputs are registered alongside the state so reset release never glitches the pins.
    always_ff @(posedge clk_200kHz or posedge reset) begin
        if (reset) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_pd    <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_WAKE;
                        r_cnt   <= '0;
                        r_pd    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAKE: begin
                    if (r_cnt == WAKE_LAST) begin
                        r_state <= S_READY;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_READY: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state <= S_HOLD;
                    r_cnt   <= '0;
                    r_pd    <= 1'b1;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_adc.PD        = r_pd;
    assign o_adc.ADC_ready = r_ready;
endmodule

// File: tb/tb_adc_pd.sv
// Bench for adc_pd: three parameterisations share clock and reset and are compared
// against an edge-count model (PD high until edge H, ready from edge H+W on).
module tb_adc_pd;
    logic clk_200kHz = 1'b0;
    logic reset      = 1'b1;

    adc_pd_if if_d ();
    adc_pd_if if_1 ();
    adc_pd_if if_255 ();

    adc_pd #(.PD_HOLD_CYCLES(20),  .WAKE_CYCLES(40)) u_dut_d (
        .clk_200kHz(clk_200kHz), .reset(reset), .o_adc(if_d));
    adc_pd #(.PD_HOLD_CYCLES(1),   .WAKE_CYCLES(1))  u_dut_1 (
        .clk_200kHz(clk_200kHz), .reset(reset), .o_adc(if_1));
    adc_pd #(.PD_HOLD_CYCLES(255), .WAKE_CYCLES(3))  u_dut_255 (
        .clk_200kHz(clk_200kHz), .reset(reset), .o_adc(if_255));

    always #5 clk_200kHz = ~clk_200kHz;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference: rising edges seen since the last reset release.
    int edges = 0;
    always @(posedge clk_200kHz or posedge reset) begin
        if (reset)
            edges <= 0;
        else if (edges < 100000)
            edges <= edges + 1;
    end

    function automatic int exp_pd(input int h);
        return (edges < h) ? 1 : 0;
    endfunction

    function automatic int exp_rdy(input int h, input int w);
        return (edges >= h + w) ? 1 : 0;
    endfunction

    bit run_checks = 1'b1;
    always @(negedge clk_200kHz) begin
        if (run_checks) begin
            check("pd_def",   int'(if_d.PD),          exp_pd(20));
            check("rdy_def",  int'(if_d.ADC_ready),   exp_rdy(20, 40));
            check("pd_1",     int'(if_1.PD),          exp_pd(1));
            check("rdy_1",    int'(if_1.ADC_ready),   exp_rdy(1, 1));
            check("pd_255",   int'(if_255.PD),        exp_pd(255));
            check("rdy_255",  int'(if_255.ADC_ready), exp_rdy(255, 3));
            check("excl_def", int'(if_d.PD & if_d.ADC_ready), 0);
            check("excl_1",   int'(if_1.PD & if_1.ADC_ready), 0);
            check("excl_255", int'(if_255.PD & if_255.ADC_ready), 0);
        end
    end

    // Assert reset 1 ns after an edge and confirm outputs respond before any clock edge.
    task automatic pulse_reset(input int hold_cycles, input int release_off);
        @(posedge clk_200kHz);
        #1 reset = 1'b1;
        #1;
        check("async_pd_def",  int'(if_d.PD), 1);
        check("async_rdy_def", int'(if_d.ADC_ready), 0);
        check("async_pd_1",    int'(if_1.PD), 1);
        check("async_rdy_1",   int'(if_1.ADC_ready), 0);
        check("async_pd_255",  int'(if_255.PD), 1);
        check("async_rdy_255", int'(if_255.ADC_ready), 0);
        repeat (hold_cycles) @(posedge clk_200kHz);
        if (hold_cycles == 0)
            #(release_off - 2) reset = 1'b0;
        else
            #(release_off) reset = 1'b0;
    endtask

    int offs[6] = '{3, 4, 6, 7, 8, 9};

    initial begin
        // Power-on reset, released between edges at 100 ns.
        #100 reset = 1'b0;
        repeat (30) @(posedge clk_200kHz);
        // 3 ns pulse during S_WAKE after edge 30.
        @(posedge clk_200kHz);
        #1 reset = 1'b1;
        #1;
        check("wake_pulse_pd",  int'(if_d.PD), 1);
        check("wake_pulse_rdy", int'(if_d.ADC_ready), 0);
        #2 reset = 1'b0;
        repeat (79) @(posedge clk_200kHz);
        // Two-cycle reset while in S_READY (edge 80).
        pulse_reset(2, 2);
        repeat (300) @(posedge clk_200kHz);
        check("final_rdy_255", int'(if_255.ADC_ready), 1);
        check("final_pd_255",  int'(if_255.PD), 0);
        // Randomised run lengths and reset pulses.
        for (int it = 0; it < 25; it++) begin
            pulse_reset($urandom_range(0, 3), offs[$urandom_range(0, 5)]);
            repeat ($urandom_range(1, 300)) @(posedge clk_200kHz);
        end
        @(negedge clk_200kHz);
        run_checks = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
